// File: rtl/slot_reel_bank.sv
// slot_reel_bank: spinning reel counters with manual/auto stop, win evaluation
// and a registered seven-segment anode/digit scan, all on one tick-enabled clock.
module slot_reel_bank #(
    parameter int NUM_REELS   = 4,
    parameter int SYM_W       = 4,
    parameter int NUM_SYMBOLS = 10,
    parameter int AUTO_TICKS  = 20
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       spin,
    input  logic [NUM_REELS-1:0]       stop,
    input  logic                       tick_spin,
    input  logic                       tick_scan,
    output logic [NUM_REELS*SYM_W-1:0] reel_val,
    output logic [NUM_REELS-1:0]       spinning,
    output logic                       busy,
    output logic                       result_valid,
    output logic                       win_all,
    output logic                       win_pair,
    output logic [NUM_REELS-1:0]       an,
    output logic [SYM_W-1:0]           digit
);
    localparam int CW = $clog2(AUTO_TICKS + 1);
    localparam int IW = $clog2(NUM_REELS);

    typedef enum logic [1:0] {IDLE, SPIN, AUTO, RESULT} state_t;

    state_t               state, state_nxt;
    logic [SYM_W-1:0]     reel [NUM_REELS];
    logic [SYM_W-1:0]     reel_nxt [NUM_REELS];
    logic [NUM_REELS-1:0] spinning_nxt, freeze, lowest;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [IW-1:0]        scan_idx, scan_nxt;
    logic                 all_eq, pair_eq;

    always_comb begin
        state_nxt    = state;
        spinning_nxt = spinning;
        cnt_nxt      = cnt;
        freeze       = '0;
        lowest       = spinning & (~spinning + 1'b1);
        for (int i = 0; i < NUM_REELS; i++) reel_nxt[i] = reel[i];
        case (state)
            IDLE: begin
                if (spin) begin
                    state_nxt    = SPIN;
                    spinning_nxt = '1;
                    cnt_nxt      = '0;
                end
            end
            SPIN, AUTO: begin
                // a reel frozen on this tick keeps its value; auto-stop picks the lowest spinning reel
                freeze       = (stop & spinning) | ((state == AUTO && tick_spin) ? lowest : '0);
                spinning_nxt = spinning & ~freeze;
                if (tick_spin)
                    for (int i = 0; i < NUM_REELS; i++)
                        if (spinning[i] && !freeze[i])
                            reel_nxt[i] = (reel[i] == SYM_W'(NUM_SYMBOLS - 1)) ? '0 : reel[i] + 1'b1;
                if (state == SPIN && tick_spin && cnt != CW'(AUTO_TICKS)) cnt_nxt = cnt + 1'b1;
                if (spinning == '0) state_nxt = RESULT;
                else if (state == SPIN && tick_spin && cnt_nxt == CW'(AUTO_TICKS)) state_nxt = AUTO;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        all_eq  = 1'b1;
        pair_eq = 1'b0;
        for (int i = 1; i < NUM_REELS; i++) begin
            all_eq  = all_eq & (reel[i] == reel[0]);
            pair_eq = pair_eq | (reel[i] == reel[i-1]);
        end
    end

    assign scan_nxt = tick_scan ? ((scan_idx == IW'(NUM_REELS - 1)) ? '0 : scan_idx + 1'b1) : scan_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            spinning     <= '0;
            cnt          <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            win_all      <= 1'b0;
            win_pair     <= 1'b0;
            scan_idx     <= '0;
            an           <= ~NUM_REELS'(1);
            digit        <= '0;
            for (int i = 0; i < NUM_REELS; i++) reel[i] <= '0;
        end else begin
            state        <= state_nxt;
            spinning     <= spinning_nxt;
            cnt          <= cnt_nxt;
            busy         <= state_nxt != IDLE;
            result_valid <= state_nxt == RESULT;
            if (state == IDLE && spin) begin
                win_all  <= 1'b0;
                win_pair <= 1'b0;
            end else if (state_nxt == RESULT) begin
                win_all  <= all_eq;
                win_pair <= pair_eq;
            end
            // an/digit are built from next-state values so they stay aligned with scan_idx and reels
            scan_idx     <= scan_nxt;
            an           <= ~(NUM_REELS'(1) << scan_nxt);
            digit        <= reel_nxt[scan_nxt];
            for (int i = 0; i < NUM_REELS; i++) reel[i] <= reel_nxt[i];
        end
    end

    for (genvar g = 0; g < NUM_REELS; g++) begin : g_pack
        assign reel_val[g*SYM_W +: SYM_W] = reel[g];
    end
endmodule

// File: tb/tb_slot_reel_bank.sv
// tb_slot_reel_bank: scenario tasks with inline checks plus a result scoreboard
// fed when each stop sequence is driven and drained on result_valid.
module tb_slot_reel_bank;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        spin = 1'b0;
    logic [3:0]  stop = '0;
    logic        tick_spin = 1'b0;
    logic        tick_scan = 1'b0;
    logic [15:0] reel_val;
    logic [3:0]  spinning, an;
    logic        busy, result_valid, win_all, win_pair;
    logic [3:0]  digit;

    typedef struct {
        logic [15:0] r;
        logic        a;
        logic        p;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    slot_reel_bank dut (
        .clk(clk), .rst_n(rst_n), .spin(spin), .stop(stop),
        .tick_spin(tick_spin), .tick_scan(tick_scan), .reel_val(reel_val),
        .spinning(spinning), .busy(busy), .result_valid(result_valid),
        .win_all(win_all), .win_pair(win_pair), .an(an), .digit(digit)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: result_valid with empty queue, reels=%h", reel_val);
            end else begin
                e = exp_q.pop_front();
                if (reel_val !== e.r || win_all !== e.a || win_pair !== e.p) begin
                    errors++;
                    $display("FAIL sb_result: got reels=%h all=%b pair=%b expected reels=%h all=%b pair=%b",
                             reel_val, win_all, win_pair, e.r, e.a, e.p);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; spin = 0; stop = '0; tick_spin = 0; tick_scan = 0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic pulse_spin();
        spin = 1'b1; step(); spin = 1'b0;
    endtask

    task automatic pulse_stop(input logic [3:0] s);
        stop = s; step(); stop = '0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_spin = 1'b1; step(); tick_spin = 1'b0;
        end
    endtask

    task automatic wait_result();
        int n = 0;
        while (result_valid !== 1'b1 && n < 20) begin step(); n++; end
        checks++;
        if (result_valid !== 1'b1) begin
            errors++;
            $display("FAIL result_timeout: result_valid=%b after %0d cycles, expected 1", result_valid, n);
        end
        step();
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL result_end: result_valid=%b busy=%b expected 0 0", result_valid, busy);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (reel_val !== 16'h0 || spinning !== 4'b0 || busy !== 1'b0 || an !== 4'b1110 ||
            digit !== 4'h0 || win_all !== 1'b0 || win_pair !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: reels=%h spin=%b busy=%b an=%b digit=%h wins=%b%b expected 0 0000 0 1110 0 00",
                     reel_val, spinning, busy, an, digit, win_all, win_pair);
        end
        step(); rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (reel_val !== 16'h0 || spinning !== 4'b0 || busy !== 1'b0 || an !== 4'b1110 || digit !== 4'h0) begin
            errors++;
            $display("FAIL reset_hold: reels=%h spin=%b busy=%b an=%b digit=%h expected 0 0000 0 1110 0",
                     reel_val, spinning, busy, an, digit);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        pulse_spin();
        checks++;
        if (busy !== 1'b1 || spinning !== 4'b1111) begin
            errors++;
            $display("FAIL spin_start: busy=%b spinning=%b expected 1 1111", busy, spinning);
        end
        ticks(13);
        exp_q.push_back('{16'h3333, 1'b1, 1'b1});
        pulse_stop(4'b1111);
        checks++;
        if (spinning !== 4'b0000 || reel_val !== 16'h3333 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_stop: spinning=%b reels=%h rv=%b expected 0000 3333 0", spinning, reel_val, result_valid);
        end
        step();
        checks++;
        if (result_valid !== 1'b1 || win_all !== 1'b1 || win_pair !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wrap_result: rv=%b all=%b pair=%b busy=%b expected 1 1 1 1", result_valid, win_all, win_pair, busy);
        end
        wait_result();
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (win_all !== 1'b1 || win_pair !== 1'b1) begin
            errors++;
            $display("FAIL win_hold: all=%b pair=%b expected 1 1", win_all, win_pair);
        end
        pulse_spin();
        checks++;
        if (win_all !== 1'b0 || win_pair !== 1'b0) begin
            errors++;
            $display("FAIL win_clear: all=%b pair=%b expected 0 0", win_all, win_pair);
        end
        exp_q.push_back('{16'h3333, 1'b1, 1'b1});
        pulse_stop(4'b1111);
        wait_result();
    endtask

    task automatic test_partial();
        do_reset();
        pulse_spin();
        ticks(3);
        pulse_stop(4'b0001);
        checks++;
        if (spinning !== 4'b1110) begin
            errors++;
            $display("FAIL partial_spin: spinning=%b expected 1110", spinning);
        end
        ticks(2);
        exp_q.push_back('{16'h5553, 1'b0, 1'b1});
        pulse_stop(4'b1110);
        wait_result();
    endtask

    task automatic test_auto();
        logic [3:0]  sp [4] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
        logic [15:0] rv [4] = '{16'h1110, 16'h2210, 16'h3210, 16'h3210};
        do_reset();
        pulse_spin();
        ticks(20);
        checks++;
        if (spinning !== 4'b1111 || reel_val !== 16'h0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL auto_t20: spinning=%b reels=%h busy=%b expected 1111 0000 1", spinning, reel_val, busy);
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 3) exp_q.push_back('{16'h3210, 1'b0, 1'b0});
            ticks(1);
            checks++;
            if (spinning !== sp[i] || reel_val !== rv[i]) begin
                errors++;
                $display("FAIL auto_t%0d: spinning=%b reels=%h expected %b %h", 21 + i, spinning, reel_val, sp[i], rv[i]);
            end
            step();
        end
        wait_result();
    endtask

    task automatic test_simul();
        do_reset();
        pulse_spin();
        ticks(2);
        tick_spin = 1'b1; stop = 4'b0100;
        step();
        tick_spin = 1'b0; stop = '0;
        checks++;
        if (reel_val !== 16'h3233 || spinning !== 4'b1011) begin
            errors++;
            $display("FAIL tick_stop: reels=%h spinning=%b expected 3233 1011", reel_val, spinning);
        end
        pulse_spin();
        checks++;
        if (busy !== 1'b1 || spinning !== 4'b1011 || reel_val !== 16'h3233) begin
            errors++;
            $display("FAIL spin_busy: busy=%b spinning=%b reels=%h expected 1 1011 3233", busy, spinning, reel_val);
        end
        exp_q.push_back('{16'h3233, 1'b0, 1'b1});
        pulse_stop(4'b1111);
        wait_result();
        spin = 1'b1; stop = 4'b1111;
        step();
        spin = 1'b0; stop = '0;
        checks++;
        if (spinning !== 4'b1111 || busy !== 1'b1) begin
            errors++;
            $display("FAIL spin_stop_idle: spinning=%b busy=%b expected 1111 1", spinning, busy);
        end
        exp_q.push_back('{16'h3233, 1'b0, 1'b1});
        pulse_stop(4'b1111);
        wait_result();
    endtask

    task automatic test_scan_reset();
        logic [3:0] ea [5] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};
        logic [3:0] ed [5] = '{4'h2, 4'h3, 4'h4, 4'h1, 4'h2};
        do_reset();
        pulse_spin();
        ticks(1); pulse_stop(4'b0001);
        ticks(1); pulse_stop(4'b0010);
        ticks(1); pulse_stop(4'b0100);
        ticks(1);
        exp_q.push_back('{16'h4321, 1'b0, 1'b0});
        pulse_stop(4'b1000);
        wait_result();
        checks++;
        if (an !== 4'b1110 || digit !== 4'h1) begin
            errors++;
            $display("FAIL scan_init: an=%b digit=%h expected 1110 1", an, digit);
        end
        for (int i = 0; i < 5; i++) begin
            tick_scan = 1'b1; step(); tick_scan = 1'b0;
            checks++;
            if (an !== ea[i] || digit !== ed[i]) begin
                errors++;
                $display("FAIL scan_%0d: an=%b digit=%h expected %b %h", i, an, digit, ea[i], ed[i]);
            end
            step();
        end
        pulse_spin();
        ticks(3);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || reel_val !== 16'h0 || spinning !== 4'b0 || an !== 4'b1110 || digit !== 4'h0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b reels=%h spinning=%b an=%b digit=%h expected 0 0000 0000 1110 0",
                     busy, reel_val, spinning, an, digit);
        end
        step(); rst_n = 1'b1; step();
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_partial();
        test_auto();
        test_simul();
        test_scan_reset();
        step(); step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d results outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/slot_reel_bank.md
# slot_reel_bank

Parametrised reel engine for the slot machine: runs NUM_REELS symbol counters that spin together on a spin request and freeze individually on per-reel stop buttons or by automatic staggered stop. It evaluates the win condition once all reels are frozen and drives a time-multiplexed digit/anode scan for the seven-segment front end. It replaces the fixed multi-clock display datapath with a single-clock, tick-enabled design.

## Interface

- NUM_REELS, 4, number of reels (2..8)
- SYM_W, 4, bits per reel symbol
- NUM_SYMBOLS, 10, symbols per reel; values 0..NUM_SYMBOLS-1 (must be ≤ 2^SYM_W)
- AUTO_TICKS, 20, spin ticks after spin start before auto-stop begins (≥1)
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- spin  in  1  one-cycle start pulse (debounced upstream)
- stop  in  NUM_REELS  one-cycle per-reel stop pulses
- tick_spin  in  1  one-cycle enable; reel advance rate
- tick_scan  in  1  one-cycle enable; display scan rate
- reel_val  out  NUM_REELS*SYM_W  reel i symbol at bits [i*SYM_W +: SYM_W]
- spinning  out  NUM_REELS  bit i high while reel i spins
- busy  out  1  high in any state other than IDLE
- result_valid  out  1  one-cycle pulse when the result is ready
- win_all  out  1  all reels equal; held until next accepted spin
- win_pair  out  1  at least one adjacent pair equal; held until next accepted spin
- an  out  NUM_REELS  active-low one-hot anode select
- digit  out  SYM_W  symbol of the currently scanned reel

## Operation

- FSM states: IDLE, SPIN, AUTO, RESULT.
- IDLE:
  - spin → SPIN.
  - spinning set to all ones; tick counter cleared; win_all and win_pair cleared.
  - stop is ignored.
- Reel advance, in SPIN and AUTO: on tick_spin, each reel with spinning=1 that is not frozen this cycle does val = (val == NUM_SYMBOLS-1) ? 0 : val+1.
- Manual stop, in SPIN and AUTO: stop[i] with spinning[i]=1 clears spinning[i]. stop[i] on an already frozen reel is ignored.
- SPIN:
  - Tick counter increments on each tick_spin.
  - On the tick that brings the counter to AUTO_TICKS, go to AUTO. Reels still advance on that tick.
- AUTO: each tick_spin freezes the lowest-index spinning reel, which does not advance on that tick.
- Any state in SPIN or AUTO: when spinning becomes all zeros, go to RESULT.
- RESULT, one cycle:
  - Register win_all and win_pair from reel_val.
  - Pulse result_valid.
  - Return to IDLE.
- Simultaneous events:
  - tick_spin together with stop[i]: reel i freezes without advancing.
  - spin while busy: ignored.
  - spin together with stop in IDLE: spin accepted, stop ignored.
- Scan:
  - scan_idx advances on tick_scan and wraps NUM_REELS-1 → 0.
  - an = ~(1 << scan_idx).
  - digit = reel scan_idx value.
  - Scan runs in every state.
- Reset, async and also mid-operation:
  - state IDLE; all reels 0; spinning 0; busy 0; result_valid 0; win flags 0.
  - scan_idx 0, so an = all ones except bit 0 low; digit 0.

## Timing

- All outputs registered. digit and an change together.
- spin sampled at cycle t: busy=1 and spinning all ones from t+1.
- Reel value updates are visible the cycle after the tick.
- Freeze event at cycle t: spinning bit clears at t+1.
- Last reel freezes at cycle t, so spinning = 0 visible at t+1: RESULT at t+2. result_valid and the new win flags are visible at t+2; busy=0 from t+3.
- A spin accepted at t+3 is valid; no dead cycles beyond RESULT.
- tick counter width: clog2(AUTO_TICKS+1). Counter saturates, so no wrap.

## Test plan

Defaults used: NUM_REELS=4, NUM_SYMBOLS=10, AUTO_TICKS=20.

- Reset: rst_n low → reel_val=0, spinning=0000, busy=0, an=1110, digit=0, win flags 0; release, hold 5 cycles → unchanged.
- Wrap and all-equal stop:
  - spin, then 13 tick_spin, then stop=1111 → all reels 3, spinning=0000.
  - result_valid pulses 2 cycles after stop; win_all=1, win_pair=1.
- Partial stops:
  - spin; 3 ticks; stop=0001; 2 more ticks; stop=1110 → reels {3,5,5,5}.
  - win_pair=1, win_all=0.
- Auto stop:
  - spin, 24 ticks, no stop → reels {0,1,2,3}.
  - spinning sequence 1111→1110→1100→1000→0000 on ticks 21..24; win_pair=0, win_all=0.
- Simultaneous events:
  - tick_spin+stop[2] same cycle → reel 2 does not advance.
  - spin pulse while busy → no restart, reel values unaffected.
- Scan and reset mid-spin:
  - 5 tick_scan → an 1101,1011,0111,1110,1101; digit tracks the reel values.
  - rst_n low during SPIN → immediate IDLE, all reels 0.
